// File: rtl/exec_dispatch.sv
// Single-issue dispatcher: hands one operation to a multicycle execution unit,
// waits for its result with a timeout and presents it as a writeback record.
module exec_dispatch #(
    parameter int N_UNIT       = 4,
    parameter int LEN_WORD     = 32,
    parameter int LEN_REG_ADDR = 6,
    parameter int TIMEOUT      = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [N_UNIT-1:0]          issue_unit,
    input  logic                       issue_write,
    input  logic [LEN_REG_ADDR-1:0]    issue_a_rd,
    output logic [N_UNIT-1:0]          unit_order,
    input  logic [N_UNIT-1:0]          unit_accepted,
    input  logic [N_UNIT-1:0]          unit_done,
    input  logic [N_UNIT*LEN_WORD-1:0] unit_data,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic                       wb_write,
    output logic [LEN_REG_ADDR-1:0]    wb_a_rd,
    output logic [LEN_WORD-1:0]        wb_data,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [31:0]                busy_cycles
);

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_ORDER = 5'b00010;
    localparam logic [4:0] ST_WAIT  = 5'b00100;
    localparam logic [4:0] ST_WB    = 5'b01000;
    localparam logic [4:0] ST_ERR   = 5'b10000;

    localparam logic [1:0]  CODE_NONE    = 2'd0;
    localparam logic [1:0]  CODE_BAD_SEL = 2'd1;
    localparam logic [1:0]  CODE_TIMEOUT = 2'd2;
    // Timer value seen in the last allowed ORDER/WAIT cycle; it reaches TIMEOUT-1 on the exit edge.
    localparam logic [15:0] TIMER_LAST   = 16'(TIMEOUT - 2);

    function automatic logic is_onehot(input logic [N_UNIT-1:0] v);
        return (v != {N_UNIT{1'b0}}) && ((v & (v - {{(N_UNIT-1){1'b0}}, 1'b1})) == {N_UNIT{1'b0}});
    endfunction

    logic [4:0]              state_r;
    logic [4:0]              state_s;
    logic [1:0]              code_s;
    logic [N_UNIT-1:0]       sel_r;
    logic                    write_r;
    logic [LEN_REG_ADDR-1:0] a_rd_r;
    logic [15:0]             timer_r;
    logic [N_UNIT-1:0]       unit_order_r;
    logic                    wb_write_r;
    logic [LEN_REG_ADDR-1:0] wb_a_rd_r;
    logic [LEN_WORD-1:0]     wb_data_r;
    logic [1:0]              err_code_r;
    logic [31:0]             busy_r;
    logic [LEN_WORD-1:0]     sel_data_s;
    logic                    transfer_s;
    logic                    accept_s;
    logic                    done_s;
    logic                    timeout_s;
    logic                    issue_ready_s;
    logic                    wb_valid_s;
    logic                    err_s;

    assign transfer_s = issue_valid && issue_ready_s;
    assign accept_s   = |(unit_accepted & sel_r);
    assign done_s     = |(unit_done & sel_r);
    assign timeout_s  = (timer_r == TIMER_LAST);

    // Result mux for the selected unit; sel_r is one-hot whenever it is used.
    always_comb begin
        sel_data_s = {LEN_WORD{1'b0}};
        for (int i = 0; i < N_UNIT; i++) begin
            if (sel_r[i]) begin
                sel_data_s = sel_data_s | unit_data[i*LEN_WORD +: LEN_WORD];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; completion takes priority over the timeout in the same cycle.
    always_comb begin
        state_s = state_r;
        code_s  = CODE_NONE;
        case (state_r)
            ST_IDLE: begin
                if (transfer_s) begin
                    if (is_onehot(issue_unit)) begin
                        state_s = ST_ORDER;
                    end else begin
                        state_s = ST_ERR;
                        code_s  = CODE_BAD_SEL;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ORDER: begin
                if (accept_s && done_s) begin
                    state_s = ST_WB;
                end else if (timeout_s) begin
                    state_s = ST_ERR;
                    code_s  = CODE_TIMEOUT;
                end else if (accept_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ORDER;
                end
            end
            ST_WAIT: begin
                if (done_s) begin
                    state_s = ST_WB;
                end else if (timeout_s) begin
                    state_s = ST_ERR;
                    code_s  = CODE_TIMEOUT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_ERR: begin
                state_s = ST_ERR;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the one-hot state flops; reset also masks issue_ready.
    always_comb begin
        issue_ready_s = 1'b0;
        wb_valid_s    = 1'b0;
        err_s         = 1'b0;
        case (state_r)
            ST_IDLE:  issue_ready_s = !rst;
            ST_WB:    wb_valid_s    = 1'b1;
            ST_ERR:   err_s         = 1'b1;
            default: begin
                issue_ready_s = 1'b0;
                wb_valid_s    = 1'b0;
                err_s         = 1'b0;
            end
        endcase
    end

    // Datapath: operation latch, order request, timer, writeback record, error code, busy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r        <= {N_UNIT{1'b0}};
            write_r      <= 1'b0;
            a_rd_r       <= {LEN_REG_ADDR{1'b0}};
            unit_order_r <= {N_UNIT{1'b0}};
            timer_r      <= 16'd0;
            wb_write_r   <= 1'b0;
            wb_a_rd_r    <= {LEN_REG_ADDR{1'b0}};
            wb_data_r    <= {LEN_WORD{1'b0}};
            err_code_r   <= CODE_NONE;
            busy_r       <= 32'd0;
        end else begin
            if (transfer_s) begin
                sel_r   <= issue_unit;
                write_r <= issue_write;
                a_rd_r  <= issue_a_rd;
            end
            if (state_s == ST_ORDER) begin
                unit_order_r <= transfer_s ? issue_unit : sel_r;
            end else begin
                unit_order_r <= {N_UNIT{1'b0}};
            end
            if (state_r == ST_IDLE) begin
                timer_r <= 16'd0;
            end else if ((state_r == ST_ORDER) || (state_r == ST_WAIT)) begin
                timer_r <= timer_r + 16'd1;
            end
            if ((state_s == ST_WB) && (state_r != ST_WB)) begin
                wb_write_r <= write_r;
                wb_a_rd_r  <= a_rd_r;
                wb_data_r  <= sel_data_s;
            end
            if ((state_s == ST_ERR) && (state_r != ST_ERR)) begin
                err_code_r <= code_s;
            end
            if (state_r != ST_IDLE) begin
                busy_r <= busy_r + 32'd1;
            end
        end
    end

    assign issue_ready = issue_ready_s;
    assign unit_order  = unit_order_r;
    assign wb_valid    = wb_valid_s;
    assign wb_write    = wb_write_r;
    assign wb_a_rd     = wb_a_rd_r;
    assign wb_data     = wb_data_r;
    assign err         = err_s;
    assign err_code    = err_code_r;
    assign busy_cycles = busy_r;

endmodule

// File: tb/tb_exec_dispatch.sv
// Randomized + directed bench for exec_dispatch; writeback records are checked
// by a scoreboard monitor, control outputs against a per-transaction reference.
module tb_exec_dispatch;

    localparam int TMO = 8;

    typedef struct packed {
        logic        wr;
        logic [5:0]  rd;
        logic [31:0] data;
    } rec_t;

    logic         clk;
    logic         rst;
    logic         issue_valid;
    logic         issue_ready;
    logic [3:0]   issue_unit;
    logic         issue_write;
    logic [5:0]   issue_a_rd;
    logic [3:0]   unit_order;
    logic [3:0]   unit_accepted;
    logic [3:0]   unit_done;
    logic [127:0] unit_data;
    logic         wb_valid;
    logic         wb_ready;
    logic         wb_write;
    logic [5:0]   wb_a_rd;
    logic [31:0]  wb_data;
    logic         err;
    logic [1:0]   err_code;
    logic [31:0]  busy_cycles;

    int   checks = 0;
    int   errors = 0;
    int   exp_busy = 0;
    rec_t exp_q[$];
    rec_t mon_r;

    exec_dispatch #(.N_UNIT(4), .LEN_WORD(32), .LEN_REG_ADDR(6), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_unit(issue_unit),
        .issue_write(issue_write), .issue_a_rd(issue_a_rd),
        .unit_order(unit_order), .unit_accepted(unit_accepted), .unit_done(unit_done),
        .unit_data(unit_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_write(wb_write), .wb_a_rd(wb_a_rd),
        .wb_data(wb_data), .err(err), .err_code(err_code), .busy_cycles(busy_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted writeback must match the oldest expected record.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected actual=rd%0d/%h required=no record", wb_a_rd, wb_data);
            end else begin
                mon_r = exp_q.pop_front();
                if ({wb_write, wb_a_rd, wb_data} !== mon_r) begin
                    errors++;
                    $display("FAIL wb_record actual=%0b/%0d/%h required=%0b/%0d/%h",
                             wb_write, wb_a_rd, wb_data, mon_r.wr, mon_r.rd, mon_r.data);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b0; issue_unit = 4'd0; issue_write = 1'b0; issue_a_rd = 6'd0;
        unit_accepted = 4'd0; unit_done = 4'd0; wb_ready = 1'b0;
        step();
        chk("rst_issue_ready", 64'(issue_ready), 64'd0);
        chk("rst_outputs", 64'({unit_order, wb_valid, wb_write, wb_a_rd, err, err_code}), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_busy", 64'(busy_cycles), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(issue_ready), 64'd1);
        exp_busy = 0;
        exp_q.delete();
    endtask

    // One operation: accept at ORDER cycle a, done at ORDER cycle d (d >= a), stall WB cycles.
    task automatic run_txn(input logic [3:0] unit, input logic wr, input logic [5:0] rd,
                           input int a, input int d, input logic [31:0] data,
                           input int stall, input logic [3:0] extra);
        int last;
        chk("issue_ready_idle", 64'(issue_ready), 64'd1);
        issue_valid = 1'b1; issue_unit = unit; issue_write = wr; issue_a_rd = rd;
        step();
        issue_valid = 1'b0; issue_unit = 4'($urandom); issue_write = 1'($urandom);
        issue_a_rd = 6'($urandom);
        if ($countones(unit) != 1) begin
            for (int k = 0; k < 3; k++) begin
                chk("bad_err", 64'({err, err_code}), 64'({1'b1, 2'd1}));
                chk("bad_order", 64'(unit_order), 64'd0);
                chk("bad_ready", 64'({issue_ready, wb_valid}), 64'd0);
                issue_valid = 1'b1;
                unit_accepted = 4'($urandom); unit_done = 4'($urandom);
                step();
            end
            issue_valid = 1'b0; unit_accepted = 4'd0; unit_done = 4'd0;
            chk("bad_busy", 64'(busy_cycles), 64'(exp_busy + 3));
            do_reset();
            return;
        end
        if (d <= TMO - 2) exp_q.push_back('{wr, rd, data});
        last = (d <= TMO - 2) ? d : TMO - 2;
        for (int idx = 0; idx <= last; idx++) begin
            chk("order_bits", 64'(unit_order), 64'((idx <= a) ? unit : 4'd0));
            chk("busy_phase", 64'({err, wb_valid, issue_ready}), 64'd0);
            unit_accepted = ((extra | 4'($urandom)) & ~unit) | ((idx == a) ? unit : 4'd0);
            unit_done     = ((extra | 4'($urandom)) & ~unit) | ((idx == d) ? unit : 4'd0);
            for (int i = 0; i < 4; i++) begin
                unit_data[i*32 +: 32] = (unit[i] && idx == d) ? data : $urandom;
            end
            step();
        end
        unit_accepted = 4'd0; unit_done = 4'd0;
        if (d <= TMO - 2) begin
            for (int s = 0; s <= stall; s++) begin
                chk("wb_valid", 64'(wb_valid), 64'd1);
                chk("wb_fields", 64'({wb_write, wb_a_rd}), 64'({wr, rd}));
                chk("wb_data", 64'(wb_data), 64'(data));
                chk("wb_quiet", 64'({issue_ready, unit_order, err}), 64'd0);
                wb_ready = (s == stall);
                unit_data = {$urandom, $urandom, $urandom, $urandom};
                unit_done = 4'($urandom);
                step();
            end
            wb_ready = 1'b0; unit_done = 4'd0;
            chk("wb_released", 64'({wb_valid, issue_ready}), 64'({1'b0, 1'b1}));
            exp_busy += (d + 1) + (stall + 1);
            chk("busy_count", 64'(busy_cycles), 64'(exp_busy));
        end else begin
            chk("tmo_err", 64'({err, err_code}), 64'({1'b1, 2'd2}));
            chk("tmo_quiet", 64'({unit_order, wb_valid, issue_ready}), 64'd0);
            chk("tmo_busy", 64'(busy_cycles), 64'(exp_busy + TMO - 1));
            do_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int a, d, r;
        logic [3:0] u;
        rst = 1'b1; wb_ready = 1'b0; unit_data = 128'd0;
        do_reset();
        // Normal: unit1, accept at cycle 2, done at cycle 6.
        run_txn(4'b0010, 1'b1, 6'd5, 1, 5, 32'hDEADBEEF, 0, 4'd0);
        chk("busy_normal", 64'(busy_cycles), 64'd7);
        // Same-cycle accept and done on unit3 while unit0 also reports done.
        run_txn(4'b1000, 1'b1, 6'd9, 0, 0, 32'h1, 0, 4'b0001);
        // Backpressure with a non-writing operation.
        run_txn(4'b0100, 1'b0, 6'd17, 1, 3, 32'hA5A5_0F0F, 5, 4'd0);
        // Timeouts: never accepted, and accepted but never done.
        run_txn(4'b0001, 1'b1, 6'd1, 20, 20, 32'h0, 0, 4'd0);
        run_txn(4'b0010, 1'b1, 6'd2, 1, 20, 32'h0, 0, 4'd0);
        // Bad selects.
        run_txn(4'b0110, 1'b1, 6'd3, 0, 0, 32'h0, 0, 4'd0);
        run_txn(4'b0000, 1'b1, 6'd3, 0, 0, 32'h0, 0, 4'd0);
        // Reset while waiting on unit0; its late completion must be dropped.
        issue_valid = 1'b1; issue_unit = 4'b0001; issue_write = 1'b1; issue_a_rd = 6'd3;
        step();
        issue_valid = 1'b0; unit_accepted = 4'b0001;
        step();
        unit_accepted = 4'd0;
        step();
        chk("mid_wait_order", 64'(unit_order), 64'd0);
        do_reset();
        unit_done = 4'b0001; unit_data[31:0] = 32'h1234_5678; wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            unit_done = 4'd0;
            chk("stale_done", 64'({wb_valid, unit_order, err}), 64'd0);
        end
        wb_ready = 1'b0;
        // Randomized operations.
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            u = (r < 2) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            a = $urandom_range(0, 4);
            d = a + $urandom_range(0, 4);
            run_txn(u, 1'($urandom), 6'($urandom), a, d, $urandom,
                    $urandom_range(0, 3), 4'd0);
        end
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_dispatch.md
EXEC_DISPATCH -- requirements
Module: exec_dispatch

Interface
REQ-001 Parameters: N_UNIT, default 4, number of multicycle execution units; LEN_WORD, default 32, data width; LEN_REG_ADDR, default 6, destination register address width; TIMEOUT, default 1024, maximum cycles in ORDER+WAIT, range 2..65535.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- issue_valid  in  1  operation offered.
- issue_ready  out  1  dispatcher can accept an operation.
- issue_unit  in  N_UNIT  one-hot unit select.
- issue_write  in  1  result is to be written to a register.
- issue_a_rd  in  LEN_REG_ADDR  destination register.
- unit_order  out  N_UNIT  per-unit start request.
- unit_accepted  in  N_UNIT  per-unit start acknowledge.
- unit_done  in  N_UNIT  per-unit one-cycle completion pulse.
- unit_data  in  N_UNIT*LEN_WORD  per-unit result; unit i occupies bits [i*LEN_WORD +: LEN_WORD].
- wb_valid  out  1  writeback record available.
- wb_ready  in  1  writeback consumer takes the record.
- wb_write  out  1  register write enable.
- wb_a_rd  out  LEN_REG_ADDR  destination register.
- wb_data  out  LEN_WORD  result.
- err  out  1  sticky error.
- err_code  out  2  0 none, 1 bad select, 2 timeout.
- busy_cycles  out  32  count of non-IDLE cycles.

Function
REQ-003 The FSM SHALL have five states, IDLE, ORDER, WAIT, WB and ERR, with one-hot encoding.
REQ-004 issue_ready SHALL be 1 only in IDLE; a transfer occurs on a cycle where issue_valid and issue_ready are both 1.
REQ-005 On a transfer, the block SHALL latch issue_unit, issue_write and issue_a_rd. If issue_unit has exactly one bit set, the FSM SHALL go to ORDER. Otherwise (zero or more than one bit set), it SHALL go to ERR with err_code=1.
REQ-006 In ORDER, unit_order[sel] SHALL be 1 and all other unit_order bits SHALL be 0. The bit SHALL stay high until a cycle in which unit_accepted[sel]=1, and drop on the following edge.
REQ-007 In ORDER, on unit_accepted[sel]=1 the FSM SHALL go to WAIT. If unit_done[sel]=1 in that same cycle, it SHALL skip WAIT: capture unit_data[sel] and go directly to WB.
REQ-008 In WAIT, on unit_done[sel]=1 the block SHALL capture unit_data[sel] into wb_data and go to WB.
REQ-009 unit_done and unit_accepted bits of non-selected units SHALL be ignored in every state.
REQ-010 Latency: a transfer at cycle 0 gives unit_order high at cycle 1. Accept and done at cycle k gives wb_valid high at cycle k+1.
REQ-011 A 16-bit timer SHALL clear on entry to ORDER and increment each cycle in ORDER or WAIT. When it equals TIMEOUT-1 without completion, the FSM SHALL go to ERR with err_code=2 and drop unit_order.
REQ-012 In WB, wb_valid SHALL be 1, and wb_write, wb_a_rd and wb_data SHALL be held stable until wb_ready=1. The FSM SHALL then return to IDLE on that edge, and issue_ready SHALL be 1 on the next cycle.
REQ-013 If issue_write=0 was latched, the record SHALL still be presented with wb_write=0, so the consumer can advance pc.
REQ-014 wb_valid SHALL be 0 outside WB. wb_data SHALL hold its last captured value until the next capture.
REQ-015 ERR SHALL be absorbing until rst: err=1, err_code held, issue_ready=0, unit_order=0, wb_valid=0.
REQ-016 busy_cycles SHALL increment in every cycle the state is not IDLE (ERR included), and wrap modulo 2^32.

Reset
REQ-017 While rst=1 at a clock edge, the block SHALL set state=IDLE, unit_order=0, wb_valid=0, wb_write=0, wb_a_rd=0, wb_data=0, err=0, err_code=0, busy_cycles=0 and timer=0.
REQ-018 issue_ready SHALL be 0 during reset and 1 on the first cycle after rst falls.
REQ-019 Reset asserted in any state, including mid-ORDER or mid-WAIT, SHALL drop unit_order on that edge. No pending result SHALL be presented afterwards.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Normal: N_UNIT=4; issue unit=0010, a_rd=5, write=1; unit1 accepted at cycle 2, done at cycle 6 with data 0xDEADBEEF -> wb_valid at cycle 7 with a_rd=5, data=0xDEADBEEF; busy_cycles=7 after wb_ready.
- Same-cycle accept and done: unit3 accepted and done together with data 0x1 -> WAIT skipped, wb_valid on the next cycle; a done from unit0 in the same cycle is ignored.
- Bad select: issue_unit=0110 -> err=1, err_code=1; unit_order stays 0; issue_ready stays 0 until rst.
- Timeout: TIMEOUT=8; unit accepts but never completes -> err_code=2 exactly 7 cycles after ORDER entry; unit_order=0.
- Backpressure: wb_ready held 0 for 5 cycles -> wb outputs stable throughout; issue_ready=0 until the cycle after wb_ready=1; issue_write=0 gives wb_write=0.
- Reset mid-WAIT: rst pulsed while waiting -> all outputs zero; a later done from the old unit produces no wb_valid.
